// File: rtl/m_unit_pkg.sv
// Shared constants and enums for the PCPI-to-M-unit issue block.
package m_unit_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } funct3_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StDrain
    } issue_state_e;

endpackage

// File: rtl/m_unit_issue_if.sv
// PCPI core handshake plus M-unit issue/response signals, bundled for m_unit_issue.
interface m_unit_issue_if;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    logic        m_valid;
    logic [31:0] m_instruction;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_ready;
    logic [31:0] m_rd;

    logic        timeout;

    // Core and M unit side, as seen by the environment.
    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, m_ready, m_rd,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  m_valid, m_instruction, m_rs1, m_rs2, timeout
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, m_ready, m_rd,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output m_valid, m_instruction, m_rs1, m_rs2, timeout
    );

endinterface

// File: rtl/m_insn_decode.sv
// Combinational match for RV32M instructions (OP opcode with MULDIV funct7, any funct3).
module m_insn_decode
    import m_unit_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [6:0] funct7_i,
    output logic       match_o
);

    assign match_o = (opcode_i == OPCODE_OP) && (funct7_i == FUNCT7_MULDIV);

endmodule

// File: rtl/m_unit_issue.sv
// Claims RV32M instructions from the PCPI port and hands them to an external M unit.
// Optional WAIT-state watchdog enabled by defining M_ISSUE_TIMEOUT_EN.
module m_unit_issue
    import m_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic           clk,
    input logic           resetn,
    m_unit_issue_if.slave bus
);

    issue_state_e state_q, state_d;
    logic         armed_q, armed_d;
    logic         wr_q, wr_d;
    logic [31:0]  result_q, result_d;
    logic [31:0]  insn_q, insn_d;
    logic [31:0]  rs1_q, rs1_d;
    logic [31:0]  rs2_q, rs2_d;
    logic         match;
    logic         to_abort;

    m_insn_decode u_decode (
        .opcode_i (bus.pcpi_insn[6:0]),
        .funct7_i (bus.pcpi_insn[31:25]),
        .match_o  (match)
    );

`ifdef M_ISSUE_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Cleared in ISSUE so the count starts at zero on the first WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIssue) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign to_abort = (state_q == StWait) && bus.pcpi_valid && !bus.m_ready &&
                      (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign to_abort   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        wr_d     = wr_q;
        result_d = result_q;
        insn_d   = insn_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;

        if (!bus.pcpi_valid) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.pcpi_valid && match && armed_q) begin
                    insn_d  = bus.pcpi_insn;
                    rs1_d   = bus.pcpi_rs1;
                    rs2_d   = bus.pcpi_rs2;
                    state_d = StIssue;
                end
            end
            StIssue, StWait: begin
                // A response arriving with the withdrawal needs no drain.
                if (!bus.pcpi_valid) begin
                    state_d = bus.m_ready ? StIdle : StDrain;
                end else if (bus.m_ready) begin
                    result_d = bus.m_rd;
                    wr_d     = 1'b1;
                    state_d  = StResp;
                end else if (to_abort) begin
                    result_d = '0;
                    wr_d     = 1'b0;
                    state_d  = StResp;
                end else if (state_q == StIssue) begin
                    state_d = StWait;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (bus.pcpi_valid) begin
                    armed_d = 1'b0;
                end
            end
            StDrain: begin
                if (bus.m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            armed_q  <= 1'b1;
            wr_q     <= 1'b0;
            result_q <= '0;
            insn_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            wr_q     <= wr_d;
            result_q <= result_d;
            insn_q   <= insn_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
        end
    end

    assign bus.m_valid       = (state_q == StIssue);
    assign bus.pcpi_wait     = (state_q == StIssue) || (state_q == StWait);
    assign bus.pcpi_ready    = (state_q == StResp);
    assign bus.pcpi_wr       = (state_q == StResp) && wr_q;
    assign bus.pcpi_rd       = (state_q == StResp) ? result_q : '0;
    assign bus.m_instruction = insn_q;
    assign bus.m_rs1         = rs1_q;
    assign bus.m_rs2         = rs2_q;
    assign bus.timeout       = to_abort;

endmodule

// File: tb/tb_m_unit_issue.sv
// Directed, table-driven bench for m_unit_issue; covers the watchdog when M_ISSUE_TIMEOUT_EN is set.
module tb_m_unit_issue;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    m_unit_issue_if bus ();

    m_unit_issue #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          lat;   // cycles from the m_valid cycle to m_ready
        logic [31:0] mrd;
        bit          match;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycle 0 presents the instruction in IDLE; the M unit answers lat cycles after m_valid.
    task automatic run_txn(input vec_t v, input string tag);
        int          issue_cyc = -1;
        int          ready_cyc = -1;
        int          mv_cnt = 0;
        int          extra = 0;
        bit          rd_leak = 0;
        bit          wait_bad = 0;
        bit          to_seen = 0;
        logic        wr_seen = 1'b0;
        logic [31:0] rd_seen = '0;
        logic [31:0] insn_at_ready = '0;
        int          ncyc = v.match ? 40 : 10;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = v.insn;
        bus.pcpi_rs1   = v.rs1;
        bus.pcpi_rs2   = v.rs2;
        bus.m_ready    = 1'b0;
        for (int c = 0; c < ncyc && ready_cyc < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.m_valid) begin
                mv_cnt++;
                issue_cyc = c;
                check({tag, " m_instruction"}, bus.m_instruction, v.insn);
                check({tag, " m_rs1"}, bus.m_rs1, v.rs1);
                check({tag, " m_rs2"}, bus.m_rs2, v.rs2);
            end
            bus.m_ready = (issue_cyc >= 0) && (c == issue_cyc + v.lat);
            bus.m_rd    = bus.m_ready ? v.mrd : 32'hDEAD_BEEF;
            #1;
            if (bus.timeout) to_seen = 1;
            if (bus.pcpi_ready) begin
                ready_cyc     = c;
                rd_seen       = bus.pcpi_rd;
                wr_seen       = bus.pcpi_wr;
                insn_at_ready = bus.m_instruction;
            end else if (bus.pcpi_rd != 32'h0) begin
                rd_leak = 1;
            end
            if (bus.pcpi_wait !== ((issue_cyc >= 0) && (ready_cyc < 0))) wait_bad = 1;
        end
        bus.m_ready = 1'b0;
        check({tag, " m_valid pulses"}, 32'(mv_cnt), v.match ? 32'd1 : 32'd0);
        check({tag, " ready latency"}, 32'(ready_cyc), v.match ? 32'(2 + v.lat) : 32'hFFFF_FFFF);
        if (v.match) begin
            check({tag, " pcpi_rd"}, rd_seen, v.mrd);
            check({tag, " pcpi_wr"}, 32'(wr_seen), 32'd1);
            check({tag, " m_instruction stable"}, insn_at_ready, v.insn);
        end
        check({tag, " pcpi_rd gated"}, 32'(rd_leak), 32'd0);
        check({tag, " pcpi_wait window"}, 32'(wait_bad), 32'd0);
        check({tag, " no timeout"}, 32'(to_seen), 32'd0);
        // Valid stays high after completion: the same instruction must not be re-accepted.
        repeat (2) begin
            @(negedge clk);
            #1;
            if (bus.m_valid || bus.pcpi_wait || bus.pcpi_ready) extra++;
        end
        check({tag, " no re-accept"}, 32'(extra), 32'd0);
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int          errs;
        int          to_cyc;
        int          rdy_cyc;
        int          to_cnt;
        logic [31:0] rd_v;
        logic        wr_v;

        vecs[0] = '{32'h0220_8033, 32'd6,          32'd7,          3, 32'd42,         1'b1};
        vecs[1] = '{32'h0020_8033, 32'd1,          32'd2,          0, 32'd0,          1'b0};
        vecs[2] = '{32'h0220_C033, 32'h8000_0000,  32'd0,          0, 32'hFFFF_FFFF,  1'b1};
        vecs[3] = '{32'h0220_B033, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, 32'hFFFF_FFFE,  1'b1};
        vecs[4] = '{32'h4020_8033, 32'd9,          32'd4,          0, 32'd0,          1'b0};
        vecs[5] = '{32'h0220_F033, 32'd17,         32'd5,          2, 32'd2,          1'b1};
        vecs[6] = '{32'h0220_8013, 32'd3,          32'd3,          0, 32'd0,          1'b0};
        vecs[7] = '{32'h0620_8033, 32'd3,          32'd3,          0, 32'd0,          1'b0};
        vecs[8] = '{32'h0220_9033, 32'd5,          32'd9,          8, 32'h0000_1234,  1'b1};
        vecs[9] = '{32'h0220_D033, 32'd100,        32'd7,          0, 32'd14,         1'b1};

        // Reset with live-looking inputs: everything must stay low.
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = 32'h0220_8033;
        bus.pcpi_rs1   = 32'd6;
        bus.pcpi_rs2   = 32'd7;
        bus.m_ready    = 1'b1;
        bus.m_rd       = 32'd123;
        repeat (3) @(negedge clk);
        #1;
        check("reset pcpi_wr", 32'(bus.pcpi_wr), 32'd0);
        check("reset pcpi_rd", bus.pcpi_rd, 32'd0);
        check("reset pcpi_wait", 32'(bus.pcpi_wait), 32'd0);
        check("reset pcpi_ready", 32'(bus.pcpi_ready), 32'd0);
        check("reset m_valid", 32'(bus.m_valid), 32'd0);
        check("reset m_instruction", bus.m_instruction, 32'd0);
        check("reset m_rs1", bus.m_rs1, 32'd0);
        check("reset m_rs2", bus.m_rs2, 32'd0);
        check("reset timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        bus.m_ready    = 1'b0;
        resetn         = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // m_ready while idle is ignored.
        @(negedge clk);
        bus.m_ready = 1'b1;
        bus.m_rd    = 32'h5555_5555;
        @(negedge clk);
        bus.m_ready = 1'b0;
        #1;
        check("idle m_ready ignored", {29'd0, bus.pcpi_ready, bus.pcpi_wait, bus.m_valid}, 32'd0);

        // Withdraw in WAIT, new instruction queued during DRAIN, stale m_ready at cycle 7.
        errs = 0;
        rd_v = '0;
        wr_v = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            bus.pcpi_valid = !(c == 3 || c == 4);
            bus.pcpi_insn  = (c < 5) ? 32'h0220_8033 : 32'h0220_C033;
            bus.pcpi_rs1   = (c < 5) ? 32'd3 : 32'd100;
            bus.pcpi_rs2   = (c < 5) ? 32'd5 : 32'd7;
            bus.m_ready    = (c == 7) || (c == 9);
            bus.m_rd       = (c == 7) ? 32'h0000_0BAD : 32'd14;
            #1;
            if (bus.m_valid !== (c == 1 || c == 9)) errs++;
            if (bus.pcpi_wait !== ((c >= 1 && c <= 3) || c == 9)) errs++;
            if (bus.pcpi_ready !== (c == 10)) errs++;
            if (c == 10) begin
                rd_v = bus.pcpi_rd;
                wr_v = bus.pcpi_wr;
            end
        end
        check("drain waveform", 32'(errs), 32'd0);
        check("drain next pcpi_rd", rd_v, 32'd14);
        check("drain next pcpi_wr", 32'(wr_v), 32'd1);
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        bus.m_ready    = 1'b0;
        @(negedge clk);

        // Reset in WAIT aborts; a later m_ready in IDLE produces nothing.
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = 32'h0220_8033;
        bus.pcpi_rs1   = 32'd11;
        bus.pcpi_rs2   = 32'd12;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid reset outputs",
              {27'd0, bus.pcpi_ready, bus.pcpi_wait, bus.m_valid, bus.pcpi_wr, bus.timeout}, 32'd0);
        check("mid reset m_rs1", bus.m_rs1, 32'd0);
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        resetn         = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b1;
        bus.m_rd    = 32'd77;
        errs = 0;
        repeat (3) begin
            #1;
            if (bus.pcpi_ready || bus.pcpi_wait || bus.m_valid) errs++;
            @(negedge clk);
            bus.m_ready = 1'b0;
        end
        check("post reset m_ready ignored", 32'(errs), 32'd0);

        // M unit never answers before the watchdog window closes.
        to_cyc  = -1;
        rdy_cyc = -1;
        to_cnt  = 0;
        rd_v    = 32'hFFFF_FFFF;
        wr_v    = 1'b1;
        errs    = 0;
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = 32'h0220_B033;
        bus.pcpi_rs1   = 32'd1;
        bus.pcpi_rs2   = 32'd2;
        bus.m_ready    = 1'b0;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
`ifndef M_ISSUE_TIMEOUT_EN
            bus.m_ready = (c == 30);
            bus.m_rd    = 32'h0BAD_F00D;
`endif
            #1;
            if (bus.timeout) begin
                to_cnt++;
                to_cyc = c;
            end
            if (bus.pcpi_ready && rdy_cyc < 0) begin
                rdy_cyc = c;
                rd_v    = bus.pcpi_rd;
                wr_v    = bus.pcpi_wr;
            end
            if (rdy_cyc < 0 && bus.pcpi_wait !== (c >= 1)) errs++;
        end
`ifdef M_ISSUE_TIMEOUT_EN
        check("timeout pulse cycle", 32'(to_cyc), 32'd9);
        check("timeout pulse width", 32'(to_cnt), 32'd1);
        check("timeout ready cycle", 32'(rdy_cyc), 32'd10);
        check("timeout pcpi_wr", 32'(wr_v), 32'd0);
        check("timeout pcpi_rd", rd_v, 32'd0);
`else
        check("long wait no timeout", 32'(to_cnt), 32'd0);
        check("long wait ready cycle", 32'(rdy_cyc), 32'd31);
        check("long wait pcpi_rd", rd_v, 32'h0BAD_F00D);
        check("long wait pcpi_wr", 32'(wr_v), 32'd1);
`endif
        check("long wait pcpi_wait", 32'(errs), 32'd0);
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        bus.m_ready    = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
